// File: rtl/md_sequencer_if.sv
// ---------------------------------------------------------------------------
// md_sequencer_if
// Bundles the CPU <-> multiply/divide sequencer signals.
//   iStart  : one-cycle start request (honoured only while idle)
//   iOp     : 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   iA, iB  : rs / rt operands
//   iMthi, iMtlo, iWdata : MTHI / MTLO write requests and data
//   oBusy   : operation in flight, CPU stalls on it
//   oDone   : one-cycle pulse, HI/LO hold the new result
//   oHi, oLo: architectural HI / LO registers
// master = CPU side, slave = sequencer side.
// ---------------------------------------------------------------------------
interface md_sequencer_if;
  logic        iStart;
  logic [1:0]  iOp;
  logic [31:0] iA;
  logic [31:0] iB;
  logic        iMthi;
  logic        iMtlo;
  logic [31:0] iWdata;
  logic        oBusy;
  logic        oDone;
  logic [31:0] oHi;
  logic [31:0] oLo;

  modport master (
    output iStart, iOp, iA, iB, iMthi, iMtlo, iWdata,
    input  oBusy, oDone, oHi, oLo
  );

  modport slave (
    input  iStart, iOp, iA, iB, iMthi, iMtlo, iWdata,
    output oBusy, oDone, oHi, oLo
  );
endinterface

// File: rtl/md_sequencer.sv
// ---------------------------------------------------------------------------
// md_sequencer
// Iterative MIPS multiply/divide unit owning HI/LO.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : md_sequencer_if.slave (start/op/operands, MTHI/MTLO, busy/done/HI/LO)
// One shift-add (multiply) or restoring-subtract (divide) step per cycle over
// a shared 64-bit accumulator p_q. Operands are reduced to magnitudes at
// start; the sign is reapplied in the FIX state.
// ---------------------------------------------------------------------------
module md_sequencer #(
  parameter int ITER = 32
) (
  input  logic           clk,
  input  logic           rst,
  md_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX
  } state_t;

  state_t      state_q;
  logic [5:0]  cnt_q;
  logic        div_q;     // 1: divide, 0: multiply
  logic        dz_q;      // divide by zero
  logic        neg_q;     // negate product / quotient
  logic        rneg_q;    // remainder takes dividend sign
  logic [63:0] p_q;       // {P_hi, P_lo} or {R, Q}
  logic [31:0] m_q;       // multiplicand magnitude or divisor magnitude
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        busy_q;
  logic        done_q;

  // Start-time operand decode
  logic        a_neg_d, b_neg_d;
  logic [31:0] abs_a_d, abs_b_d;

  // Step datapath
  logic [32:0] sum_d;
  logic [63:0] mul_next_d;
  logic [33:0] trial_d;
  logic [63:0] div_next_d;

  // Sign-corrected results
  logic [63:0] prod_d;
  logic [31:0] quo_d;
  logic [31:0] rem_d;

  always_comb begin
    // Only the signed ops (iOp[0]==0) look at the sign bits
    a_neg_d = ~bus.iOp[0] & bus.iA[31];
    b_neg_d = ~bus.iOp[0] & bus.iB[31];
    // -0x80000000 wraps to 0x80000000, which is the correct unsigned magnitude
    abs_a_d = a_neg_d ? -bus.iA : bus.iA;
    abs_b_d = b_neg_d ? -bus.iB : bus.iB;

    sum_d      = {1'b0, p_q[63:32]} + (p_q[0] ? {1'b0, m_q} : 33'd0);
    mul_next_d = {sum_d, p_q[31:1]};

    // Extra top bit so the borrow shows up as the sign of a 34-bit difference
    trial_d    = {1'b0, p_q[63:32], p_q[31]} - {2'b00, m_q};
    div_next_d = trial_d[33] ? {p_q[62:0], 1'b0}
                             : {trial_d[31:0], p_q[30:0], 1'b1};

    prod_d = neg_q  ? -p_q         : p_q;
    quo_d  = neg_q  ? -p_q[31:0]   : p_q[31:0];
    rem_d  = rneg_q ? -p_q[63:32]  : p_q[63:32];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 6'd0;
      div_q   <= 1'b0;
      dz_q    <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      p_q     <= 64'd0;
      m_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.iStart) begin
            div_q   <= bus.iOp[1];
            dz_q    <= (bus.iB == 32'd0);
            neg_q   <= a_neg_d ^ b_neg_d;
            rneg_q  <= a_neg_d;
            cnt_q   <= 6'd0;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
            if (bus.iOp[1]) begin
              p_q <= {32'd0, abs_a_d};
              m_q <= abs_b_d;
            end else begin
              p_q <= {32'd0, abs_b_d};
              m_q <= abs_a_d;
            end
          end else begin
            if (bus.iMthi) hi_q <= bus.iWdata;
            if (bus.iMtlo) lo_q <= bus.iWdata;
          end
        end

        S_RUN: begin
          p_q   <= div_q ? div_next_d : mul_next_d;
          cnt_q <= cnt_q + 6'd1;
          if (cnt_q == 6'(ITER - 1)) state_q <= S_FIX;
        end

        S_FIX: begin
          if (div_q) begin
            // With a zero divisor every trial succeeds, so R ends as |A| and
            // rem_d restores the original dividend; only LO needs forcing.
            lo_q <= dz_q ? 32'hFFFF_FFFF : quo_d;
            hi_q <= rem_d;
          end else begin
            hi_q <= prod_d[63:32];
            lo_q <= prod_d[31:0];
          end
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.oBusy = busy_q;
  assign bus.oDone = done_q;
  assign bus.oHi   = hi_q;
  assign bus.oLo   = lo_q;

endmodule
